fg_panel_ctrl: RTL
==================

// Module: fg_panel_ctrl
// PURPOSE
//  Front-panel controller for the DDS function generator. Consumes single-cycle press pulses from four
//  debounced button interfaces (MODE, STEP, UP, DOWN) and maintains the waveform select, frequency tuning
//  word and amplitude. Each change is committed to the DDS core over a valid/ready handshake.
//  Sits between the button debouncers and the phase-accumulator/waveform datapath.
// PARAMETERS
//  FTW_W    32          frequency tuning word width
//  AMP_W    8           amplitude word width
//  FTW_INIT 32'd42950   FTW after reset
//  FTW_MAX  32'h7FFF_FFFF  upper saturation limit for FTW (Nyquist)
//  AMP_INIT 8'd128      amplitude after reset
//  ACK_TO   16'd1000    cycles to wait for iCfgReady before abort
// PORTS
//  Fg_CLK       in   1      system clock
//  Ext_RESETn   in   1      asynchronous active-low reset
//  iBtnMode     in   1      press pulse: advance edited field
//  iBtnStep     in   1      press pulse: advance step index
//  iBtnUp       in   1      press pulse: increment field
//  iBtnDown     in   1      press pulse: decrement field
//  iCfgReady    in   1      DDS core accepts configuration
//  oCfgValid    out  1      configuration outputs valid, hold until accepted
//  oWaveSel     out  2      0 sine, 1 square, 2 triangle, 3 sawtooth
//  oFtw         out  FTW_W  frequency tuning word
//  oAmp         out  AMP_W  amplitude word
//  oFieldSel    out  2      field being edited: 0 WAVE, 1 FREQ, 2 AMP (for display)
//  oStepIdx     out  2      FREQ step index (for display)
//  oCfgErr      out  1      one-cycle pulse: handshake timed out
// BEHAVIOUR
//  Reset (async, any state): oCfgValid=0, oCfgErr=0, oWaveSel=0, oFtw=FTW_INIT, oAmp=AMP_INIT,
//   oFieldSel=0, oStepIdx=0. The pending event and the timeout counter clear. State = IDLE.
//  Event capture: on simultaneous pulses, only the highest priority is kept: MODE > STEP > UP > DOWN.
//   Lower-priority pulses in the same cycle are dropped.
//  FSM: IDLE -> APPLY -> COMMIT -> IDLE.
//   IDLE: a captured event in cycle N moves to APPLY at N+1.
//   APPLY (one cycle): updates the registers, then goes to COMMIT.
//    MODE: oFieldSel steps 0->1->2->0. Does not trigger a commit (APPLY returns to IDLE).
//    STEP: oStepIdx increments mod 4. Returns to IDLE, no commit.
//    UP/DOWN: the field selected by oFieldSel changes as follows.
//     WAVE: oWaveSel +/-1, mod 4 (wraps).
//     FREQ: oFtw +/- (1 << 4*oStepIdx). Saturates at FTW_MAX and 0. The sum uses FTW_W+1 bits, no overflow.
//     AMP: oAmp +/-1. Saturates at 2^AMP_W-1 and 0.
//     A saturated no-change still commits.
//   COMMIT: oCfgValid=1 from cycle N+2. Outputs are stable while valid.
//    Handshake completes when iCfgReady=1 with oCfgValid=1; oCfgValid=0 next cycle, return to IDLE.
//    If ACK_TO cycles elapse without ready: oCfgValid drops and oCfgErr pulses for 1 cycle.
//     The updated values are kept.
//  Press during APPLY/COMMIT: latched into a 1-deep pending slot; a higher-priority press overwrites it.
//   The pending event is taken in IDLE on the next cycle.
//  iCfgReady outside COMMIT is ignored.
// STRUCTURE
//  Shared package fg_ctrl_pkg holds:
//   state encodings (IDLE/APPLY/COMMIT)
//   field codes (WAVE/FREQ/AMP)
//   wave codes (SINE/SQUARE/TRI/SAW)
//   event codes (NONE/MODE/STEP/UP/DOWN)
//  One sub-module, fg_sat_addsub: combinational saturating add/sub (WIDTH, MAX params) used for FTW and AMP.
//  Everything else is inline: event priority encoder, pending slot, FSM, timeout counter.
// TESTING
//  1. Reset, then observe -> oFtw=42950, oAmp=128, oWaveSel=0, oCfgValid=0; no activity for 20 cycles.
//  2. MODE, MODE, then UP; ready tied high -> oFieldSel=2; oAmp=129; oCfgValid high 1 cycle at N+2.
//  3. FREQ field: STEP, STEP (idx=2), UP with oFtw=FTW_MAX-10 -> oFtw=FTW_MAX (saturated) and commit.
//     Then DOWN from oFtw=5 at idx 0 -> 4.
//  4. UP and DOWN same cycle, WAVE field, oWaveSel=3 -> only UP applied, oWaveSel=0 (wrap).
//  5. iCfgReady held low -> oCfgValid high exactly ACK_TO cycles, oCfgErr pulse once, then back to IDLE.
//     UP during the wait is processed after the abort.
//  6. Ext_RESETn low during COMMIT -> oCfgValid=0 immediately (async), all outputs at reset values,
//     pending event discarded.

Source files
------------

// File: rtl/fg_ctrl_pkg.sv
// Shared types for the function-generator front panel: FSM states, edited field,
// waveform and button-event codes, plus the event priority helpers.
package fg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLD_WAVE = 2'd0,
    FLD_FREQ = 2'd1,
    FLD_AMP  = 2'd2
  } field_e;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // Numerically smaller non-NONE code means higher priority.
  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_MODE = 3'd1,
    EV_STEP = 3'd2,
    EV_UP   = 3'd3,
    EV_DOWN = 3'd4
  } event_e;

  function automatic event_e ev_encode(input logic mode, input logic step,
                                       input logic up, input logic down);
    if (mode)      return EV_MODE;
    else if (step) return EV_STEP;
    else if (up)   return EV_UP;
    else if (down) return EV_DOWN;
    else           return EV_NONE;
  endfunction

  function automatic logic ev_outranks(input event_e a, input event_e b);
    return (a != EV_NONE) && ((b == EV_NONE) || (a < b));
  endfunction

  function automatic field_e field_next(input field_e f);
    case (f)
      FLD_WAVE: return FLD_FREQ;
      FLD_FREQ: return FLD_AMP;
      default:  return FLD_WAVE;
    endcase
  endfunction

endpackage

// File: rtl/fg_panel_ctrl_if.sv
// Configuration handshake towards the DDS core: waveform, tuning word and
// amplitude qualified by valid/ready.
interface fg_panel_ctrl_if #(
  parameter int unsigned FTW_W = 32,
  parameter int unsigned AMP_W = 8
);
  logic             iCfgReady;
  logic             oCfgValid;
  logic [1:0]       oWaveSel;
  logic [FTW_W-1:0] oFtw;
  logic [AMP_W-1:0] oAmp;

  modport master (
    input  iCfgReady,
    output oCfgValid, oWaveSel, oFtw, oAmp
  );

  modport slave (
    output iCfgReady,
    input  oCfgValid, oWaveSel, oFtw, oAmp
  );
endinterface

// File: rtl/fg_sat_addsub.sv
// Combinational add/subtract clamped to [0, MAX]; the add is done one bit wider
// so a carry out of WIDTH bits still saturates instead of wrapping.
module fg_sat_addsub #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  MAX   = '1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    if (sub_i) begin
      y_o = (b_i > a_i) ? '0 : (a_i - b_i);
    end else if (sum > {1'b0, MAX}) begin
      y_o = MAX;
    end else begin
      y_o = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fg_panel_ctrl.sv
// Front-panel controller: turns button press pulses into edits of waveform,
// tuning word and amplitude, and commits each edit to the DDS core.
module fg_panel_ctrl
  import fg_ctrl_pkg::*;
#(
  parameter int unsigned       FTW_W    = 32,
  parameter int unsigned       AMP_W    = 8,
  parameter logic [FTW_W-1:0]  FTW_INIT = FTW_W'(42950),
  parameter logic [FTW_W-1:0]  FTW_MAX  = FTW_W'(32'h7FFF_FFFF),
  parameter logic [AMP_W-1:0]  AMP_INIT = AMP_W'(128),
  parameter logic [15:0]       ACK_TO   = 16'd1000
) (
  input  logic             Fg_CLK,
  input  logic             Ext_RESETn,
  input  logic             iBtnMode,
  input  logic             iBtnStep,
  input  logic             iBtnUp,
  input  logic             iBtnDown,
  fg_panel_ctrl_if.master  cfg,
  output logic [1:0]       oFieldSel,
  output logic [1:0]       oStepIdx,
  output logic             oCfgErr
);

  state_e           state_q, state_d;
  event_e           pend_q, pend_d;
  event_e           cur_q, cur_d;
  event_e           in_ev;
  field_e           field_q, field_d;
  logic [1:0]       step_q, step_d;
  logic [1:0]       wave_q, wave_d;
  logic [FTW_W-1:0] ftw_q, ftw_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      tmo_q, tmo_d;

  logic             dec;
  logic [FTW_W-1:0] ftw_delta;
  logic [FTW_W-1:0] ftw_adj;
  logic [AMP_W-1:0] amp_adj;

  assign in_ev     = ev_encode(iBtnMode, iBtnStep, iBtnUp, iBtnDown);
  assign dec       = (cur_q == EV_DOWN);
  assign ftw_delta = FTW_W'(1) << {step_q, 2'b00};

  fg_sat_addsub #(
    .WIDTH (FTW_W),
    .MAX   (FTW_MAX)
  ) u_ftw_sat (
    .a_i   (ftw_q),
    .b_i   (ftw_delta),
    .sub_i (dec),
    .y_o   (ftw_adj)
  );

  fg_sat_addsub #(
    .WIDTH (AMP_W),
    .MAX   ({AMP_W{1'b1}})
  ) u_amp_sat (
    .a_i   (amp_q),
    .b_i   (AMP_W'(1)),
    .sub_i (dec),
    .y_o   (amp_adj)
  );

  always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
    if (!Ext_RESETn) begin
      state_q <= ST_IDLE;
      pend_q  <= EV_NONE;
      cur_q   <= EV_NONE;
      field_q <= FLD_WAVE;
      step_q  <= '0;
      wave_q  <= WAVE_SINE;
      ftw_q   <= FTW_INIT;
      amp_q   <= AMP_INIT;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      field_q <= field_d;
      step_q  <= step_d;
      wave_q  <= wave_d;
      ftw_q   <= ftw_d;
      amp_q   <= amp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    field_d = field_q;
    step_d  = step_q;
    wave_d  = wave_q;
    ftw_d   = ftw_q;
    amp_d   = amp_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        // A pending press goes first; a fresh press in the same cycle refills the slot.
        if (pend_q != EV_NONE) begin
          cur_d   = pend_q;
          pend_d  = in_ev;
          state_d = ST_APPLY;
        end else if (in_ev != EV_NONE) begin
          cur_d   = in_ev;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        if (ev_outranks(in_ev, pend_q)) pend_d = in_ev;
        state_d = ST_IDLE;
        case (cur_q)
          EV_MODE: field_d = field_next(field_q);
          EV_STEP: step_d  = step_q + 2'd1;
          EV_UP, EV_DOWN: begin
            case (field_q)
              FLD_WAVE: wave_d = dec ? (wave_q - 2'd1) : (wave_q + 2'd1);
              FLD_FREQ: ftw_d  = ftw_adj;
              default:  amp_d  = amp_adj;
            endcase
            valid_d = 1'b1;
            tmo_d   = '0;
            state_d = ST_COMMIT;
          end
          default: ;
        endcase
      end

      ST_COMMIT: begin
        if (ev_outranks(in_ev, pend_q)) pend_d = in_ev;
        if (cfg.iCfgReady) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_q == ACK_TO - 16'd1) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg.oCfgValid = valid_q;
  assign cfg.oWaveSel  = wave_q;
  assign cfg.oFtw      = ftw_q;
  assign cfg.oAmp      = amp_q;
  assign oFieldSel     = field_q;
  assign oStepIdx      = step_q;
  assign oCfgErr       = err_q;

endmodule
